// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the RV32 subset datapath. It steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives the datapath enables and memory handshakes, and halts on traps.
module multicycle_ctrl #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             takebranch,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             regwrite,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             alusrc,
  output logic             branch,
  output logic [1:0]       aluop,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_LWI  = 7'b0000111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_NOP  = 7'b0000000;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_IMEM    = 2'd2;
  localparam logic [1:0] TRAP_DMEM    = 2'd3;

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  logic [2:0]        state_q, state_d;
  logic [6:0]        op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        trap_q, trap_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              retire;

  logic is_r, is_ialu, is_lw, is_sw, is_lwi, is_br, is_nop;
  logic is_load, is_memop, is_exec_op;

  // Only the opcode field matters to the sequencer.
  logic unused_instr;
  assign unused_instr = ^instr[31:7];

  always_comb begin
    is_r       = (op_q == OP_R);
    is_ialu    = (op_q == OP_IALU);
    is_lw      = (op_q == OP_LW);
    is_sw      = (op_q == OP_SW);
    is_lwi     = (op_q == OP_LWI);
    is_br      = (op_q == OP_BR);
    is_nop     = (op_q == OP_NOP);
    is_load    = is_lw | is_lwi;
    is_memop   = is_load | is_sw;
    is_exec_op = is_r | is_ialu | is_memop | is_br;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = wait_q;
    trap_d    = trap_q;
    retire    = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    regwrite  = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 1'b0;
    alusrc    = 1'b0;
    branch    = 1'b0;
    aluop     = 2'd0;
    halted    = 1'b0;

    case (state_q)
      S_FETCH: begin
        // run is a raw input, so gate with rst to keep the request low during reset.
        imem_req = run & rst;
        if (imem_req) begin
          if (imem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            op_d    = instr[6:0];
            wait_d  = '0;
            state_d = S_DECODE;
          end else if (wait_q == WAIT_LIM) begin
            wait_d  = '0;
            trap_d  = TRAP_IMEM;
            state_d = S_HALT;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end else begin
          wait_d = '0;
        end
      end

      S_DECODE: begin
        if (is_exec_op) begin
          state_d = S_EXEC;
        end else if (is_nop) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          trap_d  = TRAP_ILLEGAL;
          state_d = S_HALT;
        end
      end

      S_EXEC: begin
        aluop  = (is_r | is_ialu) ? 2'd2 : (is_br ? 2'd1 : 2'd0);
        alusrc = is_ialu | is_lw | is_sw;
        if (is_br) begin
          branch  = 1'b1;
          pc_we   = takebranch;
          pc_src  = takebranch;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_memop) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        memread  = is_load;
        memwrite = is_sw;
        if (dmem_ready) begin
          wait_d = '0;
          if (is_sw) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LIM) begin
          wait_d  = '0;
          trap_d  = TRAP_DMEM;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_WB: begin
        regwrite = 1'b1;
        memtoreg = is_load;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
    endcase

    cyc_d     = (state_q != S_HALT) ? cyc_q + CNT_W'(1) : cyc_q;
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      op_q      <= OP_NOP;
      wait_q    <= '0;
      trap_q    <= TRAP_NONE;
      cyc_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      trap_q    <= trap_d;
      cyc_q     <= cyc_d;
      instret_q <= instret_d;
    end
  end

  assign state       = state_q;
  assign trap_cause  = trap_q;
  assign cyc_cnt     = cyc_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors and inputs are queued,
// then replayed cycle by cycle against the DUT along with the cycle/retire counters.
module tb_multicycle_ctrl;

  localparam int W = 19;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] instr;
  logic        takebranch;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req, dmem_req, ir_we, pc_we, pc_src, regwrite;
  logic        memread, memwrite, memtoreg, alusrc, branch, halted;
  logic [1:0]  aluop, trap_cause;
  logic [2:0]  state;
  logic [31:0] cyc_cnt, instret_cnt;

  logic [W-1:0] exp_q[$];
  logic [4:0]   stim_q[$];
  logic [W-1:0] obs;
  logic [31:0]  exp_cyc, exp_ret;
  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.CNT_W(32), .WAIT_MAX(16)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .takebranch(takebranch),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .alusrc(alusrc), .branch(branch), .aluop(aluop),
    .state(state), .halted(halted), .trap_cause(trap_cause),
    .cyc_cnt(cyc_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {state, imem_req, dmem_req, ir_we, pc_we, pc_src, regwrite, memread,
                memwrite, memtoreg, alusrc, branch, aluop, halted, trap_cause};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic ireq, dreq, irwe,
                                      pcwe, pcsrc, rw, mr, mw, m2r, asrc, br,
                                      input logic [1:0] aop, input logic hlt,
                                      input logic [1:0] tc);
    return {st, ireq, dreq, irwe, pcwe, pcsrc, rw, mr, mw, m2r, asrc, br, aop, hlt, tc};
  endfunction

  function automatic logic [W-1:0] f_idle();
    return '0;
  endfunction
  function automatic logic [W-1:0] f_wait();
    return mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0);
  endfunction
  function automatic logic [W-1:0] f_hs();
    return mk(3'd0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0);
  endfunction
  function automatic logic [W-1:0] dec();
    return mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0);
  endfunction
  function automatic logic [W-1:0] ex(input logic [1:0] aop, input logic asrc, br, pcwe);
    return mk(3'd2, 0, 0, 0, pcwe, pcwe, 0, 0, 0, 0, asrc, br, aop, 0, 2'd0);
  endfunction
  function automatic logic [W-1:0] mem(input logic rd, wr);
    return mk(3'd3, 0, 1, 0, 0, 0, 0, rd, wr, 0, 0, 0, 2'd0, 0, 2'd0);
  endfunction
  function automatic logic [W-1:0] wb(input logic m2r);
    return mk(3'd4, 0, 0, 0, 0, 0, 1, 0, 0, m2r, 0, 0, 2'd0, 0, 2'd0);
  endfunction
  function automatic logic [W-1:0] hlt(input logic [1:0] tc);
    return mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, tc);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input logic [W-1:0] v, input logic r, ir, dr, tb, ret);
    exp_q.push_back(v);
    stim_q.push_back({r, ir, dr, tb, ret});
  endtask

  // Replays queued steps; entered and left just after a negedge.
  task automatic drain(input string tag);
    logic [4:0]   s;
    logic [W-1:0] e;
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      run        = s[4];
      imem_ready = s[3];
      dmem_ready = s[2];
      takebranch = s[1];
      #1;
      chk($sformatf("%s outs c%0d", tag, n), 32'(obs), 32'(e));
      if (e[W-1:W-3] != 3'd7) exp_cyc++;
      if (s[0]) exp_ret++;
      @(negedge clk);
      chk($sformatf("%s cyc_cnt c%0d", tag, n), cyc_cnt, exp_cyc);
      chk($sformatf("%s instret c%0d", tag, n), instret_cnt, exp_ret);
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; takebranch = 1'b1;
    #1;
    chk("reset outs", 32'(obs), 32'(f_idle()));
    chk("reset cyc_cnt", cyc_cnt, 32'd0);
    chk("reset instret", instret_cnt, 32'd0);
    @(negedge clk);
    #1;
    chk("reset held outs", 32'(obs), 32'(f_idle()));
    rst = 1'b1;
    exp_cyc = 0;
    exp_ret = 0;
  endtask

  initial begin
    instr = 32'h0;
    do_reset();

    // addi: 4 cycles, regwrite only in WB
    instr = 32'h00500113;
    push(f_hs(), 1, 1, rb(), rb(), 0);
    push(dec(), 1, rb(), rb(), rb(), 0);
    push(ex(2'd2, 1, 0, 0), 1, rb(), rb(), rb(), 0);
    push(wb(0), 1, rb(), rb(), rb(), 1);
    drain("addi");
    chk("addi instret", instret_cnt, 32'd1);

    // lw with three dmem wait cycles: 8 cycles total
    instr = 32'h0000a003;
    push(f_hs(), 1, 1, rb(), rb(), 0);
    push(dec(), 1, rb(), rb(), rb(), 0);
    push(ex(2'd0, 1, 0, 0), 1, rb(), rb(), rb(), 0);
    for (int i = 0; i < 3; i++) push(mem(1, 0), 1, rb(), 0, rb(), 0);
    push(mem(1, 0), 1, rb(), 1, rb(), 0);
    push(wb(1), 1, rb(), rb(), rb(), 1);
    drain("lw");

    // beq taken then not taken
    instr = 32'h00108063;
    push(f_hs(), 1, 1, rb(), rb(), 0);
    push(dec(), 1, rb(), rb(), rb(), 0);
    push(ex(2'd1, 0, 1, 1), 1, rb(), rb(), 1, 1);
    drain("beq_t");
    push(f_hs(), 1, 1, rb(), rb(), 0);
    push(dec(), 1, rb(), rb(), rb(), 0);
    push(ex(2'd1, 0, 1, 0), 1, rb(), rb(), 0, 1);
    drain("beq_nt");

    // sw with zero-wait memory: 4 cycles
    instr = 32'h0020a023;
    push(f_hs(), 1, 1, rb(), rb(), 0);
    push(dec(), 1, rb(), rb(), rb(), 0);
    push(ex(2'd0, 1, 0, 0), 1, rb(), rb(), rb(), 0);
    push(mem(0, 1), 1, rb(), 1, rb(), 1);
    drain("sw");

    // R-type add
    instr = 32'h002081b3;
    push(f_hs(), 1, 1, rb(), rb(), 0);
    push(dec(), 1, rb(), rb(), rb(), 0);
    push(ex(2'd2, 0, 0, 0), 1, rb(), rb(), rb(), 0);
    push(wb(0), 1, rb(), rb(), rb(), 1);
    drain("radd");

    // lwi: 5 cycles, no immediate operand
    instr = 32'h00000007;
    push(f_hs(), 1, 1, rb(), rb(), 0);
    push(dec(), 1, rb(), rb(), rb(), 0);
    push(ex(2'd0, 0, 0, 0), 1, rb(), rb(), rb(), 0);
    push(mem(1, 0), 1, rb(), 1, rb(), 0);
    push(wb(1), 1, rb(), rb(), rb(), 1);
    drain("lwi");

    // run low holds FETCH with no request, then nop in 2 cycles
    instr = 32'h00000000;
    push(f_idle(), 0, 1, rb(), rb(), 0);
    push(f_idle(), 0, 0, rb(), rb(), 0);
    push(f_hs(), 1, 1, rb(), rb(), 0);
    push(dec(), 1, rb(), rb(), rb(), 1);
    drain("nop");

    // imem ready arriving exactly at the wait limit: handshake wins
    for (int i = 0; i < 16; i++) push(f_wait(), 1, 0, rb(), rb(), 0);
    push(f_hs(), 1, 1, rb(), rb(), 0);
    push(dec(), 1, rb(), rb(), rb(), 1);
    drain("imem_edge");

    // reset asserted during MEM of a store
    instr = 32'h0020a023;
    push(f_hs(), 1, 1, rb(), rb(), 0);
    push(dec(), 1, rb(), rb(), rb(), 0);
    push(ex(2'd0, 1, 0, 0), 1, rb(), rb(), rb(), 0);
    push(mem(0, 1), 1, rb(), 0, rb(), 0);
    drain("sw_rst");
    dmem_ready = 1'b0;
    #1;
    chk("sw_rst pre outs", 32'(obs), 32'(mem(0, 1)));
    rst = 1'b0;
    #1;
    chk("sw_rst outs", 32'(obs), 32'(f_idle()));
    chk("sw_rst instret", instret_cnt, 32'd0);
    chk("sw_rst cyc_cnt", cyc_cnt, 32'd0);
    @(negedge clk);
    do_reset();

    // illegal opcode: HALT after DECODE, counters frozen
    instr = 32'hFFFFFFFF;
    push(f_hs(), 1, 1, rb(), rb(), 0);
    push(dec(), 1, rb(), rb(), rb(), 0);
    for (int i = 0; i < 3; i++) push(hlt(2'd1), 1, rb(), rb(), rb(), 0);
    drain("illegal");
    do_reset();

    // imem stuck: HALT after 16 counted waits plus the limit cycle
    instr = 32'h00500113;
    for (int i = 0; i < 17; i++) push(f_wait(), 1, 0, rb(), rb(), 0);
    for (int i = 0; i < 2; i++) push(hlt(2'd2), 1, rb(), rb(), rb(), 0);
    drain("imem_to");
    do_reset();

    // dmem stuck on a load
    instr = 32'h0000a003;
    push(f_hs(), 1, 1, rb(), rb(), 0);
    push(dec(), 1, rb(), rb(), rb(), 0);
    push(ex(2'd0, 1, 0, 0), 1, rb(), rb(), rb(), 0);
    for (int i = 0; i < 17; i++) push(mem(1, 0), 1, rb(), 0, rb(), 0);
    for (int i = 0; i < 2; i++) push(hlt(2'd3), 1, rb(), rb(), rb(), 0);
    drain("dmem_to");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
